fetch_unit: RTL and testbench

Instruction-fetch front end of the RISC-V core. Holds the program counter and issues word fetches to instruction memory, using the existing `adder` block to form PC+4. Returned instructions are buffered, paired with their PC, in a small FIFO for the decode stage. Execute-stage redirects (taken branch/jump) flush in-flight and buffered work.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/adder.sv | 14 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction-fetch front end.
//   XLEN_DEFAULT     : default address/data width (RV32)
//   RESET_PC_DEFAULT : default program counter after reset
//   INST_NOP         : canonical RV32 NOP (addi x0, x0, 0)
//   fetch_state_t    : fetch FSM state
//   fetch_entry_t    : instruction buffer entry {pc, inst}
package fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,      // nothing outstanding
    WAIT,      // one request outstanding, response will be kept
    WAIT_DROP  // one request outstanding, response will be discarded
  } fetch_state_t;

  // Entry fields are fixed at RV32 width; the fetch unit is only used with XLEN = 32.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/adder.sv
// adder -- shared combinational adder block (sum modulo 2^WIDTH).
//   i_A, i_B : operands
//   o_S      : sum, carry out dropped
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_S
);

  assign o_S = i_A + i_B;

endmodule

// File: rtl/fetch_fifo.sv
// fetch_fifo -- DEPTH-entry synchronous FIFO for fetched instructions.
//   clk, rst_n  : clock, synchronous active-low reset
//   push, data  : write an entry
//   pop         : drop the head entry
//   flush       : empty the FIFO; wins over push and pop
//   head        : current head entry (valid when !empty)
//   count       : number of stored entries
//   full, empty : status
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; entries are only observed through
  // count/empty, which are reset, so resetting the data would only cost area.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end of the RV32 core.
// Holds the PC, issues one word fetch at a time and buffers returned
// instructions with their PC for decode. A redirect loads a new PC, flushes
// the buffer and marks any outstanding response for discard.
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_redirect, i_redirect_pc : execute-stage redirect pulse and target
//   o_imem_req, o_imem_addr   : fetch request and address (= PC)
//   i_imem_gnt                : request accepted this cycle
//   i_imem_rvalid/_rdata      : in-order response
//   o_inst_valid/_inst/_pc    : buffer head to decode
//   i_inst_ready              : decode consumes head when valid && ready
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_plus4, inflight_pc;
  logic [CW-1:0]   count, count_after;
  logic            full, empty;
  logic            push, pop, grant, req;
  fetch_entry_t    push_entry, head_entry;

  adder #(.WIDTH(XLEN)) u_pc_adder (
    .i_A (pc),
    .i_B (XLEN'(4)),
    .o_S (pc_plus4)
  );

  // A redirect flushes the buffer, so neither the pop nor a same-cycle
  // response may touch it. The full guard never blocks in practice: the
  // request gating already keeps a slot free for every outstanding fetch.
  assign pop   = o_inst_valid && i_inst_ready && !i_redirect;
  assign push  = i_imem_rvalid && (state == WAIT) && !i_redirect && (!full || pop);
  assign count_after = count + CW'(push) - CW'(pop);
  assign grant = req && i_imem_gnt;

  assign push_entry = '{pc: inflight_pc, inst: i_imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .data  (push_entry),
    .pop   (pop),
    .flush (i_redirect),
    .head  (head_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    req        = 1'b0;

    // A new request may issue once the previous one has returned (or none is
    // outstanding), and only if its response is guaranteed a buffer slot.
    if (i_rst_n && !i_redirect && (count_after < CW'(DEPTH)) &&
        ((state == IDLE) || i_imem_rvalid)) begin
      req = 1'b1;
    end

    if (grant) begin
      state_next = WAIT;
    end else if ((state != IDLE) && i_imem_rvalid) begin
      state_next = IDLE;
    end else if (i_redirect && (state == WAIT)) begin
      state_next = WAIT_DROP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      state <= state_next;
      if (i_redirect) begin
        pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      end else if (grant) begin
        pc <= pc_plus4;
      end
      if (grant) inflight_pc <= pc;
    end
  end

  assign o_imem_req   = req;
  assign o_imem_addr  = pc;
  assign o_inst_valid = !empty;
  // Head fields read as zero whenever nothing valid is presented.
  assign o_inst       = o_inst_valid ? head_entry.inst : '0;
  assign o_inst_pc    = o_inst_valid ? head_entry.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// A small instruction memory model answers each grant after a configurable
// latency with a word derived from the address.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  int          lat = 1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;

  // values observed in the current cycle, before its rising edge
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_inst, obs_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_inst_valid  (inst_valid),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .i_inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // One clock cycle: present the memory response at the falling edge,
  // sample DUT outputs, advance the memory model, then cross the rising edge.
  task automatic step();
    @(negedge clk);
    imem_rvalid = pend && (pend_wait == 0);
    imem_rdata  = imem_rvalid ? mem_word(pend_addr) : INST_NOP;
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = inst_valid;
    obs_inst  = inst;
    obs_pc    = inst_pc;
    if (imem_rvalid) pend = 1'b0;
    else if (pend)   pend_wait--;
    if (rst_n && imem_req && imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_wait = lat - 1;
    end
    if (!rst_n) pend = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b1;
    inst_ready  = 1'b1;
    lat         = 1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; inst_ready = 1'b1; lat = 1;
    step();
    step();
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", obs_req); end
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
    n_checks++; if (obs_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", obs_inst); end
    n_checks++; if (obs_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", obs_pc); end
    rst_n = 1'b1;
    step();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00000000", obs_req, obs_addr);
    end
  endtask

  // Immediate grant, 1-cycle response, decode always ready: one per cycle.
  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_req c%0d: got req=%b addr=%h want req=1 addr=%h", k, obs_req, obs_addr, 32'(4 * k));
      end
      if (k >= 2) begin
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'(4 * (k - 2)) ||
                        obs_inst !== mem_word(32'(4 * (k - 2)))) begin
          n_fail++; $display("FAIL stream_out c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                             k, obs_valid, obs_pc, obs_inst, 32'(4 * (k - 2)), mem_word(32'(4 * (k - 2))));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int req_count;
    int delivered;
    logic [31:0] expect_pc;
    do_reset();
    inst_ready = 1'b0;
    req_count  = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (obs_req) req_count++;
      if (k >= 2) begin
        n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
          n_fail++; $display("FAIL bp_hold c%0d: got v=%b pc=%h want v=1 pc=00000000", k, obs_valid, obs_pc);
        end
      end
    end
    n_checks++; if (req_count !== 2) begin
      n_fail++; $display("FAIL bp_req_count: got %0d want 2", req_count);
    end
    inst_ready = 1'b1;
    delivered  = 0;
    expect_pc  = 32'h0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (obs_valid) begin
        n_checks++; if (obs_pc !== expect_pc || obs_inst !== mem_word(expect_pc)) begin
          n_fail++; $display("FAIL bp_drain: got pc=%h inst=%h want pc=%h inst=%h", obs_pc, obs_inst, expect_pc, mem_word(expect_pc));
        end
        expect_pc = expect_pc + 32'd4;
        delivered++;
      end
    end
    n_checks++; if (delivered !== 10) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d want 10", delivered);
    end
  endtask

  task automatic test_redirect_outstanding();
    bit found;
    do_reset();
    lat = 2;
    step();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      n_fail++; $display("FAIL rdo_first: got req=%b addr=%h want req=1 addr=00000000", obs_req, obs_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rdo_req_during: got %b want 0", obs_req); end
    redirect = 1'b0;
    step();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0000_0100 || obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdo_after: got req=%b addr=%h v=%b want req=1 addr=00000100 v=0", obs_req, obs_addr, obs_valid);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (obs_valid) begin
        found = 1'b1;
        n_checks++; if (obs_pc !== 32'h0000_0100 || obs_inst !== mem_word(32'h0000_0100)) begin
          n_fail++; $display("FAIL rdo_first_out: got pc=%h inst=%h want pc=00000100 inst=%h", obs_pc, obs_inst, mem_word(32'h100));
        end
      end
    end
    if (!found) begin
      n_checks++; n_fail++; $display("FAIL rdo_timeout: got no valid within 10 cycles want pc=00000100");
    end
  endtask

  task automatic test_redirect_full();
    // Redirect coinciding with a response that would fill the buffer.
    do_reset();
    inst_ready = 1'b0;
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
      n_fail++; $display("FAIL rdf_pre: got v=%b pc=%h want v=1 pc=00000000", obs_valid, obs_pc);
    end
    redirect = 1'b0;
    step();
    n_checks++; if (obs_valid !== 1'b0 || obs_addr !== 32'h0000_0200 || obs_req !== 1'b1) begin
      n_fail++; $display("FAIL rdf_flush: got v=%b addr=%h req=%b want v=0 addr=00000200 req=1", obs_valid, obs_addr, obs_req);
    end
    step();
    step();
    n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0000_0200 || obs_inst !== mem_word(32'h200)) begin
      n_fail++; $display("FAIL rdf_refill: got v=%b pc=%h inst=%h want v=1 pc=00000200 inst=%h", obs_valid, obs_pc, obs_inst, mem_word(32'h200));
    end

    // Redirect with the buffer full and decode ready: pop ignored, both flushed.
    do_reset();
    inst_ready = 1'b0;
    step();
    step();
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0300; inst_ready = 1'b1;
    step();
    n_checks++; if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL rdf_full_pre: got v=%b req=%b want v=1 req=0", obs_valid, obs_req);
    end
    redirect = 1'b0;
    step();
    n_checks++; if (obs_valid !== 1'b0 || obs_addr !== 32'h0000_0300 || obs_req !== 1'b1) begin
      n_fail++; $display("FAIL rdf_full_flush: got v=%b addr=%h req=%b want v=0 addr=00000300 req=1", obs_valid, obs_addr, obs_req);
    end
    step();
    step();
    n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0000_0300) begin
      n_fail++; $display("FAIL rdf_full_refill: got v=%b pc=%h want v=1 pc=00000300", obs_valid, obs_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    step();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_top: got req=%b addr=%h want req=1 addr=fffffffc", obs_req, obs_addr);
    end
    step();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_zero: got req=%b addr=%h want req=1 addr=00000000", obs_req, obs_addr);
    end
    step();
    n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'hFFFF_FFFC || obs_inst !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_out0: got v=%b pc=%h inst=%h want v=1 pc=fffffffc", obs_valid, obs_pc, obs_inst);
    end
    step();
    n_checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
      n_fail++; $display("FAIL wrap_out1: got v=%b pc=%h want v=1 pc=00000000", obs_valid, obs_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) step();
    n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got v=%b want 1", obs_valid); end
    rst_n = 1'b0;
    step();
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_in_reset: got %b want 0", obs_req); end
    rst_n = 1'b1;
    step();
    n_checks++; if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h0) begin
      n_fail++; $display("FAIL rmid_after: got v=%b req=%b addr=%h want v=0 req=1 addr=00000000", obs_valid, obs_req, obs_addr);
    end
  endtask

  task automatic test_no_grant();
    do_reset();
    imem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0 || obs_valid !== 1'b0) begin
        n_fail++; $display("FAIL nogrant_hold c%0d: got req=%b addr=%h v=%b want req=1 addr=00000000 v=0", k, obs_req, obs_addr, obs_valid);
      end
    end
    imem_gnt = 1'b1;
    step();
    step();
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h4) begin
      n_fail++; $display("FAIL nogrant_release: got req=%b addr=%h want req=1 addr=00000004", obs_req, obs_addr);
    end
  endtask

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = INST_NOP;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    test_no_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
